pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter LEN_W, default 8: width of the stretch-length input.
REQ-002 Parameter GAP_CYC, default 4: minimum number of low cycles on o_level between two stretches; 0 is legal.
REQ-003 Parameter CNT_W, default 8: width of the accepted-pulse counter.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_pulse  in  1  single-cycle enable pulse, the kind an edge detector produces; sampled every clock edge.
REQ-007 i_len  in  LEN_W  stretch length in clock cycles; sampled only when a pulse is accepted or reloaded.
REQ-008 i_retrig  in  1  1 means a pulse arriving during a stretch reloads the stretch; 0 means it is dropped.
REQ-009 i_clear  in  1  synchronous clear of o_count and o_dropped.
REQ-010 o_level  out  1  stretched level, registered.
REQ-011 o_done  out  1  one-cycle pulse marking the end of each stretch.
REQ-012 o_count  out  CNT_W  number of accepted pulses, saturating.
REQ-013 o_dropped  out  1  sticky flag: at least one pulse was discarded.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, HOLD and GAP.
REQ-015 Length L SHALL equal i_len; i_len==0 SHALL be treated as L=1.
REQ-016 IDLE, i_pulse=1 at edge k: the block SHALL latch L, enter HOLD, and drive o_level=1 for exactly L cycles, starting in the cycle after edge k.
REQ-017 HOLD, i_pulse=1, i_retrig=1: the hold counter SHALL reload with the current L, so o_level stays 1 for L further cycles after that edge; this applies on every HOLD cycle, the last one included.
REQ-018 HOLD, i_pulse=1, i_retrig=0: the pulse SHALL be dropped, o_dropped SHALL be set, and the stretch timing SHALL not change.
REQ-019 End of HOLD: o_level SHALL go 0 and o_done SHALL be 1 for exactly that first low cycle. If GAP_CYC>0 the FSM SHALL enter GAP; otherwise it SHALL enter IDLE.
REQ-020 GAP SHALL keep o_level=0 for exactly GAP_CYC cycles, with the o_done cycle counted as the first of them.
REQ-021 GAP, i_pulse=1 with no pending request: the block SHALL set the pending flag and latch L. A further pulse while pending SHALL be dropped and SHALL set o_dropped.
REQ-022 GAP end with pending set: the FSM SHALL go directly to HOLD, so o_level rises in the cycle after the last gap cycle. With pending clear, the FSM SHALL go to IDLE.
REQ-023 A pulse sampled on the last GAP cycle SHALL count as pending.
REQ-024 GAP_CYC=0: a pulse arriving in the o_done cycle SHALL be accepted as if in IDLE.
REQ-025 o_count SHALL increment by 1 on each accepted pulse: an IDLE start, a HOLD reload, or a GAP pending latch. Dropped pulses SHALL not increment it. It SHALL saturate at 2^CNT_W-1.
REQ-026 i_clear=1 SHALL zero o_count and o_dropped at the next edge; it SHALL not affect the FSM, o_level or pending.
REQ-027 i_clear and an accepted pulse in the same cycle: o_count SHALL become 1.
REQ-028 All outputs SHALL be driven directly from registers.

Reset
REQ-029 i_rst=1 at an edge SHALL force IDLE, clear pending, and set o_level=0, o_done=0, o_count=0, o_dropped=0 from the next cycle.
REQ-030 Reset during HOLD or GAP SHALL abort without asserting o_done.
REQ-031 Reset SHALL take priority over i_pulse and i_clear.
REQ-032 The first pulse after reset deasserts SHALL be accepted from IDLE.

Verification
REQ-033 i_len=5, single pulse -> o_level high exactly 5 cycles; o_done in the 6th cycle; o_count=1.
REQ-034 i_len=6, i_retrig=1, second pulse 3 cycles after the first -> o_level high 3+6=9 cycles continuously; o_count=2.
REQ-035 i_len=6, i_retrig=0, second pulse during HOLD -> o_level high 6 cycles; o_dropped=1; o_count=1.
REQ-036 GAP_CYC=4, pulse on gap cycle 2 and again on gap cycle 3 -> o_level low exactly 4 cycles then high for L; o_dropped=1; o_count=2.
REQ-037 i_rst pulsed mid-HOLD -> o_level=0 next cycle; no o_done; o_count=0.
REQ-038 CNT_W=2, 5 spaced pulses -> o_count saturates at 3; i_clear -> o_count=0, o_dropped=0.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle pulses into level stretches of programmable
// length, with optional retrigger, an enforced low gap and an accepted-pulse counter.
module pulse_stretcher #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_pulse,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_retrig,
    input  logic             i_clear,
    output logic             o_level,
    output logic             o_done,
    output logic [CNT_W-1:0] o_count,
    output logic             o_dropped
);

    localparam int unsigned GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [LEN_W-1:0]   hold_cnt, hold_cnt_n;
    logic [LEN_W-1:0]   pend_len, pend_len_n;
    logic [LEN_W-1:0]   len_m1;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic               pending, pending_n;
    logic               level_n, done_n, dropped_n;
    logic [CNT_W-1:0]   count_n;
    logic               accept, drop;

    // Counters hold "cycles remaining after this one", so a length of 0 acts as 1.
    assign len_m1 = (i_len == '0) ? '0 : i_len - LEN_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        gap_cnt_n  = gap_cnt;
        pending_n  = pending;
        pend_len_n = pend_len;
        level_n    = o_level;
        done_n     = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;

        case (state)
            IDLE: begin
                if (i_pulse) begin
                    accept     = 1'b1;
                    state_n    = HOLD;
                    hold_cnt_n = len_m1;
                    level_n    = 1'b1;
                end
            end
            HOLD: begin
                if (i_pulse && i_retrig) begin
                    accept     = 1'b1;
                    hold_cnt_n = len_m1;
                end else begin
                    drop = i_pulse;
                    if (hold_cnt == '0) begin
                        level_n = 1'b0;
                        done_n  = 1'b1;
                        if (GAP_CYC > 0) begin
                            state_n   = GAP;
                            gap_cnt_n = GAP_LAST;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        hold_cnt_n = hold_cnt - LEN_W'(1);
                    end
                end
            end
            GAP: begin
                if (i_pulse) begin
                    if (!pending) begin
                        accept     = 1'b1;
                        pending_n  = 1'b1;
                        pend_len_n = len_m1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                // A pulse on the final gap cycle still launches the next stretch.
                if (gap_cnt == '0) begin
                    if (pending_n) begin
                        state_n    = HOLD;
                        level_n    = 1'b1;
                        hold_cnt_n = pend_len_n;
                        pending_n  = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                level_n = 1'b0;
            end
        endcase

        if (i_clear) begin
            count_n = accept ? CNT_W'(1) : '0;
        end else if (accept && (o_count != '1)) begin
            count_n = o_count + CNT_W'(1);
        end else begin
            count_n = o_count;
        end
        dropped_n = (i_clear ? 1'b0 : o_dropped) | drop;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            pending   <= 1'b0;
            pend_len  <= '0;
            o_level   <= 1'b0;
            o_done    <= 1'b0;
            o_count   <= '0;
            o_dropped <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_cnt_n;
            gap_cnt   <= gap_cnt_n;
            pending   <= pending_n;
            pend_len  <= pend_len_n;
            o_level   <= level_n;
            o_done    <= done_n;
            o_count   <= count_n;
            o_dropped <= dropped_n;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: two instances (gap of 4 with a 2-bit counter, and no gap)
// checked every cycle against a timeline model, plus directed literal checks.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst, pulse, retrig, clear;
    logic [7:0] len;

    logic       a_level, a_done, a_dropped;
    logic [1:0] a_count;
    logic       b_level, b_done, b_dropped;
    logic [7:0] b_count;

    pulse_stretcher #(.LEN_W(8), .GAP_CYC(4), .CNT_W(2)) dut_a (
        .clk(clk), .i_rst(rst), .i_pulse(pulse), .i_len(len), .i_retrig(retrig),
        .i_clear(clear), .o_level(a_level), .o_done(a_done), .o_count(a_count),
        .o_dropped(a_dropped)
    );

    pulse_stretcher #(.LEN_W(8), .GAP_CYC(0), .CNT_W(8)) dut_b (
        .clk(clk), .i_rst(rst), .i_pulse(pulse), .i_len(len), .i_retrig(retrig),
        .i_clear(clear), .o_level(b_level), .o_done(b_done), .o_count(b_count),
        .o_dropped(b_dropped)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Timeline model: a stretch is the cycle interval [hi_start, hi_end);
    // the mandatory low gap is [hi_end, hi_end + gap).
    int gap_cyc[2]  = '{4, 0};
    int cnt_max[2]  = '{3, 255};
    int cyc         = 0;
    bit armed       = 1'b0;
    int hi_start[2], hi_end[2], plen[2], m_count[2];
    bit stretched[2], pending[2], m_dropped[2];

    always @(posedge clk) begin
        int  l;
        bit  acc, drp;
        for (int i = 0; i < 2; i++) begin
            l   = (len == 0) ? 1 : int'(len);
            acc = 1'b0;
            drp = 1'b0;
            if (rst) begin
                stretched[i] = 1'b0; pending[i] = 1'b0; m_dropped[i] = 1'b0;
                hi_start[i]  = 0;    hi_end[i]  = 0;    m_count[i]   = 0;
                plen[i]      = 0;
                armed        = 1'b1;
            end else begin
                if (stretched[i] && hi_start[i] <= cyc && cyc < hi_end[i]) begin
                    if (pulse && retrig) begin
                        acc = 1'b1;
                        hi_end[i] = cyc + 1 + l;
                    end else if (pulse) begin
                        drp = 1'b1;
                    end
                end else if (stretched[i] && cyc >= hi_end[i] && cyc < hi_end[i] + gap_cyc[i]) begin
                    if (pulse) begin
                        if (!pending[i]) begin
                            pending[i] = 1'b1; plen[i] = l; acc = 1'b1;
                        end else begin
                            drp = 1'b1;
                        end
                    end
                    if (cyc + 1 == hi_end[i] + gap_cyc[i] && pending[i]) begin
                        hi_start[i] = cyc + 1;
                        hi_end[i]   = cyc + 1 + plen[i];
                        pending[i]  = 1'b0;
                    end
                end else if (pulse) begin
                    acc = 1'b1;
                    stretched[i] = 1'b1;
                    hi_start[i]  = cyc + 1;
                    hi_end[i]    = cyc + 1 + l;
                end
                if (clear)                          m_count[i] = acc ? 1 : 0;
                else if (acc && m_count[i] < cnt_max[i]) m_count[i] = m_count[i] + 1;
                m_dropped[i] = (clear ? 1'b0 : m_dropped[i]) | drp;
            end
        end
        cyc++;
    end

    // Per-cycle comparison plus run-length monitors on the DUT outputs
    int hi_run[2], low_run[2], last_hi[2], last_low[2];
    int rise_cyc[2], done_cyc[2], done_cnt[2];
    bit prev_lvl[2];

    always @(negedge clk) begin
        bit lv, dn, dr;
        int cn;
        bit e_lv, e_dn;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                lv = (i == 0) ? a_level : b_level;
                dn = (i == 0) ? a_done : b_done;
                dr = (i == 0) ? a_dropped : b_dropped;
                cn = (i == 0) ? int'(a_count) : int'(b_count);
                e_lv = stretched[i] && hi_start[i] <= cyc && cyc < hi_end[i];
                e_dn = stretched[i] && cyc == hi_end[i];
                check($sformatf("dut%0d.level@%0d", i, cyc), int'(lv), int'(e_lv));
                check($sformatf("dut%0d.done@%0d", i, cyc), int'(dn), int'(e_dn));
                check($sformatf("dut%0d.count@%0d", i, cyc), cn, m_count[i]);
                check($sformatf("dut%0d.dropped@%0d", i, cyc), int'(dr), int'(m_dropped[i]));
                if (lv) begin
                    if (!prev_lvl[i]) begin
                        last_low[i] = low_run[i];
                        rise_cyc[i] = cyc;
                    end
                    hi_run[i]++;
                    low_run[i] = 0;
                end else begin
                    if (prev_lvl[i]) last_hi[i] = hi_run[i];
                    hi_run[i] = 0;
                    low_run[i]++;
                end
                if (dn) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                end
                prev_lvl[i] = lv;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int l, input bit rt);
        pulse = 1'b1; len = 8'(l); retrig = rt;
        tick(1);
        pulse = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        int d0;
        rst = 1'b1; pulse = 1'b0; len = 8'd0; retrig = 1'b0; clear = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("reset_count_a", int'(a_count), 0);
        check("reset_level_a", int'(a_level), 0);

        // Single stretch of 5
        send(5, 0); tick(12);
        check("len5_run", last_hi[0], 5);
        check("len5_done_offset", done_cyc[0] - rise_cyc[0], 5);
        check("len5_done_cnt", done_cnt[0], 1);
        check("len5_count", int'(a_count), 1);
        check("len5_model_count", m_count[0], 1);
        do_clear();

        // Retrigger three cycles in
        send(6, 1); tick(2); send(6, 1); tick(16);
        check("retrig_run", last_hi[0], 9);
        check("retrig_count", int'(a_count), 2);
        do_clear();

        // Pulse dropped during hold
        send(6, 0); tick(2); send(6, 0); tick(14);
        check("drop_run", last_hi[0], 6);
        check("drop_flag", int'(a_dropped), 1);
        check("drop_count", int'(a_count), 1);
        do_clear();

        // Pulses on gap cycles 2 and 3
        send(3, 0); tick(4); send(3, 0); send(3, 0); tick(14);
        check("gap_run", last_hi[0], 3);
        check("gap_low", last_low[0], 4);
        check("gap_dropped", int'(a_dropped), 1);
        check("gap_count", int'(a_count), 2);
        check("gap_model_count", m_count[0], 2);
        check("nogap_low", last_low[1], 2);
        check("nogap_count", int'(b_count), 2);
        do_clear();

        // Pulse in the done cycle
        send(2, 0); tick(2); send(2, 0); tick(14);
        check("donecyc_nogap_low", last_low[1], 1);
        check("donecyc_gap_low", last_low[0], 4);
        do_clear();

        // Pulse on the last gap cycle
        send(2, 0); tick(5); send(2, 0); tick(14);
        check("lastgap_low", last_low[0], 4);
        check("lastgap_count", int'(a_count), 2);

        // Zero length acts as one; retrigger on the final hold cycle
        send(0, 0); tick(8);
        check("len0_run", last_hi[0], 1);
        send(3, 1); tick(2); send(3, 1); tick(14);
        check("retrig_last_run", last_hi[0], 6);
        check("retrig_last_run_b", last_hi[1], 6);
        do_clear();

        // Reset mid-hold
        d0 = done_cnt[0];
        send(8, 0); tick(3);
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(12);
        check("rst_run", last_hi[0], 4);
        check("rst_no_done", done_cnt[0], d0);
        check("rst_count", int'(a_count), 0);
        send(2, 0); tick(8);
        check("post_rst_count", int'(a_count), 1);
        check("post_rst_run", last_hi[0], 2);
        do_clear();

        // Saturation and clear
        for (int n = 0; n < 5; n++) begin
            send(1, 0); tick(7);
        end
        check("sat_count_a", int'(a_count), 3);
        check("sat_count_b", int'(b_count), 5);
        send(4, 0); tick(1); send(4, 0); tick(12);
        check("sat_dropped", int'(a_dropped), 1);
        do_clear();
        check("clear_count", int'(a_count), 0);
        check("clear_dropped", int'(a_dropped), 0);

        // Clear together with an accepted pulse
        clear = 1'b1; send(2, 0); clear = 1'b0;
        check("clear_accept_a", int'(a_count), 1);
        check("clear_accept_b", int'(b_count), 1);
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
